dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
- MEM-stage sequencer between the EX/MEM pipeline register and a req/gnt/rvalid data-memory port.
- Decodes load/store width from funct3 and issues one bus transaction per memory instruction.
- Holds the pipeline with stall until the transaction completes; formats load data for write-back.
- Also handles misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 16, max cycles spent in REQ+WAIT before abort; range 2..255
CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
ld_en  input  1  MEM-stage instruction is a load
st_en  input  1  MEM-stage instruction is a store; ld_en and st_en both high is illegal, treated as load
addr  input  32  effective address (ALU result)
wdata  input  32  store data (rs2)
funct3  input  3  width/sign field from MEM-stage instruction
stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM registers
load_data  output  32  formatted load result, registered
misalign_err  output  1  one-cycle pulse: misaligned access dropped
bus_err  output  1  one-cycle pulse: transaction timed out
dmem_req  output  1  bus request
dmem_we  output  1  1 = write
dmem_addr  output  32  word-aligned address {addr[31:2],2'b00}
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-replicated store data
dmem_gnt  input  1  request accepted
dmem_rvalid  input  1  read data valid
dmem_rdata  input  32  read data

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0.
  - Outputs: stall=0, load_data=0, misalign_err=0, bus_err=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0.
- States and transitions: IDLE, REQ, WAIT, DONE.
  - IDLE, no ld_en/st_en: stay; stall=0.
  - IDLE, access aligned: capture addr/wdata/funct3/type into internal regs; go to REQ next cycle. stall=1 combinationally in this same cycle.
  - IDLE, misaligned (halfword with addr[0]=1, or word with addr[1:0]!=0): no bus request; misalign_err=1 for this cycle; stall=0; stay IDLE.
  - REQ: dmem_req=1 with dmem_we/addr/be/wdata from captured regs, held stable until gnt. Store with gnt goes to DONE; load with gnt goes to WAIT.
  - WAIT: dmem_req=0. dmem_rvalid arrives no earlier than the cycle after gnt. On rvalid: load_data is registered; go to DONE.
  - DONE: stall=0 for exactly one cycle so the pipeline advances; then go to IDLE. DONE never samples ld_en/st_en, so no re-issue of the same instruction.
- stall=1 in IDLE (aligned access request), REQ and WAIT.
- Latency: a load with gnt in the first REQ cycle and rvalid the next cycle stalls for 3 cycles (IDLE-detect, REQ, WAIT); DONE is the 4th cycle.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES without completion: dmem_req drops, bus_err pulses for 1 cycle, load_data=0, go to DONE.
  - Late rvalid/gnt after abort is ignored.
- Store encoding (funct3):
  - 000 SB: be=1<<addr[1:0]; wdata={4{wdata[7:0]}}.
  - 001 SH: be=addr[1]?1100:0011; wdata={2{wdata[15:0]}}.
  - 010 SW: be=1111.
  - Other funct3 values are treated as SW.
- Load formatting (on rvalid, using captured addr[1:0]):
  - 000 LB and 100 LBU: select byte lane; sign- or zero-extend respectively.
  - 001 LH and 101 LHU: select half by addr[1]; sign- or zero-extend respectively.
  - 010 LW: pass through.
  - Other funct3 values are treated as LW.
  - dmem_be=1111 for all loads.
- load_data holds its value until the next completed load or a timeout.
- Simultaneous gnt and timeout expiry in the same cycle: gnt wins.
- Reset mid-transaction: immediate return to IDLE, dmem_req drops asynchronously; the bus must tolerate an abandoned request.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt on first REQ cycle -> one-cycle req with we=1, be=1111, dmem_addr=0x100; stall high 2 cycles, low in DONE.
- SB addr=0x103, wdata=0x000000A5 -> be=1000, dmem_wdata=0xA5A5A5A5.
- LB addr=0x202, rdata=0x12804433, gnt immediate, rvalid 3 cycles later -> load_data=0xFFFFFF80 and stall held throughout WAIT; repeat as LHU addr=0x202 -> 0x00001280.
- LW addr=0x105 -> misalign_err pulse, dmem_req never asserts, stall stays 0.
- Load with gnt never asserted, TIMEOUT_CYCLES=16 -> req for 16 cycles, bus_err pulse, load_data=0, DONE, IDLE.
- rst asserted during WAIT -> dmem_req=0 and stall=0 immediately; subsequent rvalid is ignored; next load completes normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues one req/gnt/rvalid transaction
// per load/store, stalls the pipeline until it completes, formats load data.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   i_ld_en, i_st_en    MEM-stage load / store (both high -> load)
//   i_addr, i_wdata     effective address, store data
//   i_funct3            width / sign field
//   o_stall             freeze upstream pipeline registers
//   o_load_data         formatted, registered load result
//   o_misalign_err      pulse: misaligned access dropped
//   o_bus_err           pulse: transaction timed out
//   o_dmem_*            request side of the data-memory port
//   i_dmem_gnt/rvalid/rdata  response side of the data-memory port
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ld_en,
  input  logic        i_st_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_funct3,
  output logic        o_stall,
  output logic [31:0] o_load_data,
  output logic        o_misalign_err,
  output logic        o_bus_err,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_is_ld;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_load_data;
  logic              r_bus_err;

  logic              w_acc;
  logic              w_is_ld;
  logic              w_byte_sz;
  logic              w_half_sz;
  logic              w_word_sz;
  logic              w_mis;
  logic [3:0]        w_be;
  logic [31:0]       w_wd;
  logic              w_tmo;

  logic              w_start;
  logic              w_stall;
  logic              w_mis_out;
  logic              w_req;
  logic              w_abort;
  logic              w_rd_done;

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_fmt;

  assign w_acc   = i_ld_en | i_st_en;
  assign w_is_ld = i_ld_en;

  // Loads decode width from funct3[1:0] (bit 2 is the unsigned flag);
  // stores only recognise 000/001, everything else is a word.
  always_comb begin
    w_byte_sz = 1'b0;
    w_half_sz = 1'b0;
    w_word_sz = 1'b0;
    unique case (1'b1)
      w_is_ld && (i_funct3[1:0] == 2'b00): w_byte_sz = 1'b1;
      w_is_ld && (i_funct3[1:0] == 2'b01): w_half_sz = 1'b1;
      !w_is_ld && (i_funct3 == 3'b000):    w_byte_sz = 1'b1;
      !w_is_ld && (i_funct3 == 3'b001):    w_half_sz = 1'b1;
      default:                             w_word_sz = 1'b1;
    endcase
  end

  assign w_mis = (w_half_sz & i_addr[0])
               | (w_word_sz & (|i_addr[1:0]));

  always_comb begin
    w_be = 4'b1111;
    w_wd = i_wdata;
    if (!w_is_ld) begin
      unique case (1'b1)
        w_byte_sz: begin
          w_be = 4'b0001 << i_addr[1:0];
          w_wd = {4{i_wdata[7:0]}};
        end
        w_half_sz: begin
          w_be = i_addr[1] ? 4'b1100 : 4'b0011;
          w_wd = {2{i_wdata[15:0]}};
        end
        default: begin
          w_be = 4'b1111;
          w_wd = i_wdata;
        end
      endcase
    end
  end

  // Budget is spent once the counter shows the last allowed cycle; a
  // grant that arrives in that same cycle still wins.
  assign w_tmo = (r_cnt >= LP_LAST);

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_stall   = 1'b0;
    w_mis_out = 1'b0;
    w_req     = 1'b0;
    w_abort   = 1'b0;
    w_rd_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (w_mis) begin
            w_mis_out = 1'b1;
          end else begin
            w_start = 1'b1;
            w_stall = 1'b1;
            w_next  = S_REQ;
          end
        end
      end
      S_REQ: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
        if (i_dmem_gnt) begin
          w_next = r_is_ld ? S_WAIT : S_DONE;
        end else if (w_tmo) begin
          w_abort = 1'b1;
          w_next  = S_DONE;
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (i_dmem_rvalid) begin
          w_rd_done = 1'b1;
          w_next    = S_DONE;
        end else if (w_tmo) begin
          w_abort = 1'b1;
          w_next  = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (r_state == S_REQ || r_state == S_WAIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_ld <= 1'b0;
      r_f3    <= 3'b000;
      r_off   <= 2'b00;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_be    <= 4'b0000;
      r_wdata <= 32'h0;
    end else if (w_start) begin
      r_is_ld <= w_is_ld;
      r_f3    <= i_funct3;
      r_off   <= i_addr[1:0];
      r_we    <= ~w_is_ld;
      r_addr  <= {i_addr[31:2], 2'b00};
      r_be    <= w_be;
      r_wdata <= w_wd;
    end
  end

  always_comb begin
    w_byte = i_dmem_rdata[7:0];
    unique case (r_off)
      2'd0: w_byte = i_dmem_rdata[7:0];
      2'd1: w_byte = i_dmem_rdata[15:8];
      2'd2: w_byte = i_dmem_rdata[23:16];
      2'd3: w_byte = i_dmem_rdata[31:24];
      default: w_byte = i_dmem_rdata[7:0];
    endcase
  end

  assign w_half = r_off[1] ? i_dmem_rdata[31:16]
                           : i_dmem_rdata[15:0];

  // funct3[2] clear means sign-extend.
  always_comb begin
    w_fmt = i_dmem_rdata;
    unique case (r_f3[1:0])
      2'b00: w_fmt = {{24{~r_f3[2] & w_byte[7]}}, w_byte};
      2'b01: w_fmt = {{16{~r_f3[2] & w_half[15]}}, w_half};
      default: w_fmt = i_dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_data <= 32'h0;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_err <= w_abort;
      if (w_rd_done) begin
        r_load_data <= w_fmt;
      end else if (w_abort) begin
        r_load_data <= 32'h0;
      end
    end
  end

  // Reset forces the IDLE-detect outputs low even if a request is
  // still presented on the inputs.
  assign o_stall        = w_stall & ~rst;
  assign o_misalign_err = w_mis_out & ~rst;
  assign o_bus_err      = r_bus_err;
  assign o_load_data    = r_load_data;
  assign o_dmem_req     = w_req;
  assign o_dmem_we      = r_we;
  assign o_dmem_addr    = r_addr;
  assign o_dmem_be      = r_be;
  assign o_dmem_wdata   = r_wdata;

endmodule
